// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU: single-cycle logic/arith/compare ops plus iterative
// shift-add MULU and restoring DIVU. Define ALU_SEQ_OVF_EN to add the ovf_o port.
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             dz_o
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] OpAnd   = 4'd0;
  localparam logic [3:0] OpOr    = 4'd1;
  localparam logic [3:0] OpNand  = 4'd2;
  localparam logic [3:0] OpNor   = 4'd3;
  localparam logic [3:0] OpAddu  = 4'd4;
  localparam logic [3:0] OpSubu  = 4'd5;
  localparam logic [3:0] OpSlt   = 4'd6;
  localparam logic [3:0] OpEqual = 4'd7;
  localparam logic [3:0] OpMulu  = 4'd8;
  localparam logic [3:0] OpDivu  = 4'd9;
  localparam logic [3:0] OpSltu  = 4'd10;

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] hi_q;
  logic             zero_q;
  logic             dz_q;
  logic             valid_q;
  logic             ready_q;

  // Single-cycle datapath, evaluated directly on the incoming operands.
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;

  always_comb begin
    sum     = src1_i + src2_i;
    diff    = src1_i - src2_i;
    alu_res = '0;
    case (ctrl_i)
      OpAnd:   alu_res = src1_i & src2_i;
      OpOr:    alu_res = src1_i | src2_i;
      OpNand:  alu_res = ~(src1_i & src2_i);
      OpNor:   alu_res = ~(src1_i | src2_i);
      OpAddu:  alu_res = sum;
      OpSubu:  alu_res = diff;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OpEqual: alu_res = {{(WIDTH-1){1'b0}}, (src1_i == src2_i)};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
      default: alu_res = '0;
    endcase
  end

  // Multiply: {hi_q, res_q} is the partial product with the multiplier shifting out of res_q.
  logic [WIDTH:0]   mul_add;
  logic [WIDTH-1:0] mul_hi_nx;
  logic [WIDTH-1:0] mul_lo_nx;

  // Divide: hi_q is the partial remainder, res_q shifts dividend bits out and quotient bits in.
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nx;
  logic [WIDTH-1:0] div_quo_nx;

  logic [WIDTH-1:0] iter_res;
  logic [WIDTH-1:0] iter_hi;

  always_comb begin
    mul_add    = {1'b0, hi_q} + (res_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_nx  = mul_add[WIDTH:1];
    mul_lo_nx  = {mul_add[0], res_q[WIDTH-1:1]};

    div_sh     = {hi_q, res_q[WIDTH-1]};
    div_sub    = div_sh - {1'b0, opnd_q};
    div_ge     = ~div_sub[WIDTH];
    div_rem_nx = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_quo_nx = {res_q[WIDTH-2:0], div_ge};

    iter_res   = is_div_q ? div_quo_nx : mul_lo_nx;
    iter_hi    = is_div_q ? div_rem_nx : mul_hi_nx;
  end

`ifdef ALU_SEQ_OVF_EN
  logic ovf_q;
  logic alu_ovf;

  always_comb begin
    alu_ovf = 1'b0;
    case (ctrl_i)
      OpAddu:  alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
      OpSubu:  alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
      default: alu_ovf = 1'b0;
    endcase
  end

  assign ovf_o = ovf_q;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      res_q    <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      dz_q     <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
`ifdef ALU_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            ready_q <= 1'b0;
            dz_q    <= 1'b0;
            zero_q  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
            if (ctrl_i == OpMulu || (ctrl_i == OpDivu && src2_i != '0)) begin
              state_q  <= StBusy;
              cnt_q    <= '0;
              is_div_q <= (ctrl_i == OpDivu);
              opnd_q   <= src2_i;
              res_q    <= src1_i;
              hi_q     <= '0;
            end else if (ctrl_i == OpDivu) begin
              // Divide by zero bypasses the iteration entirely.
              state_q <= StDone;
              valid_q <= 1'b1;
              res_q   <= '1;
              hi_q    <= src1_i;
              dz_q    <= 1'b1;
            end else begin
              state_q <= StDone;
              valid_q <= 1'b1;
              res_q   <= alu_res;
              hi_q    <= '0;
              zero_q  <= (alu_res == '0);
`ifdef ALU_SEQ_OVF_EN
              ovf_q   <= alu_ovf;
`endif
            end
          end
        end
        StBusy: begin
          res_q <= iter_res;
          hi_q  <= iter_hi;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            state_q <= StDone;
            valid_q <= 1'b1;
            zero_q  <= (iter_res == '0);
`ifdef ALU_SEQ_OVF_EN
            ovf_q   <= ~is_div_q && (iter_hi != '0);
`endif
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign result_o    = res_q;
  assign hi_o        = hi_q;
  assign zero_o      = zero_q;
  assign dz_o        = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed literal cases plus randomized ops,
// all checked every cycle against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [3:0]   ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] hi;
  logic         zero;
  logic         dz;
`ifdef ALU_SEQ_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .src1_i      (src1),
    .src2_i      (src2),
    .ctrl_i      (ctrl),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .hi_o        (hi),
    .zero_o      (zero),
    .dz_o        (dz)
`ifdef ALU_SEQ_OVF_EN
    ,
    .ovf_o       (ovf)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: expected outputs and latency straight from the opcode table.
  task automatic ref_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic [W-1:0] h, output logic z,
                        output logic d, output logic o, output int lat);
    logic [63:0] p;
    longint      sa, sb, s, lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = 64'sh7FFF_FFFF;
    h   = '0;
    d   = 1'b0;
    o   = 1'b0;
    lat = 1;
    case (c)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = ~(a & b);
      4'd3: r = ~(a | b);
      4'd4: begin r = a + b; s = sa + sb; o = (s > lim) || (s < -lim - 1); end
      4'd5: begin r = a - b; s = sa - sb; o = (s > lim) || (s < -lim - 1); end
      4'd6: r = (sa < sb) ? 1 : 0;
      4'd7: r = (a == b) ? 1 : 0;
      4'd8: begin
        p   = 64'(a) * 64'(b);
        r   = p[W-1:0];
        h   = p[63:W];
        o   = (h != 0);
        lat = W + 1;
      end
      4'd9: begin
        if (b == 0) begin
          r = '1;
          h = a;
          d = 1'b1;
        end else begin
          r   = a / b;
          h   = a % b;
          lat = W + 1;
        end
      end
      4'd10: r = (a < b) ? 1 : 0;
      default: r = '0;
    endcase
    z = (r == 0);
  endtask

  // Compare process: sampled on the falling edge, predicts the next rising edge.
  bit           pending = 0;
  int           k = 0;
  int           e_lat = 1;
  logic [W-1:0] e_res, e_hi;
  logic         e_zero, e_dz, e_ovf;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pending = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_result", result, 0);
      chk("rst_hi", hi, 0);
      chk("rst_zero", zero, 0);
      chk("rst_dz", dz, 0);
`ifdef ALU_SEQ_OVF_EN
      chk("rst_ovf", ovf, 0);
`endif
    end else begin
      bit ev;
      if (pending) k++;
      ev = pending && (k >= e_lat);
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, !pending);
      if (ev) begin
        chk("result", result, e_res);
        chk("hi", hi, e_hi);
        chk("zero", zero, e_zero);
        chk("dz", dz, e_dz);
`ifdef ALU_SEQ_OVF_EN
        chk("ovf", ovf, e_ovf);
`endif
      end
      if (ev && out_ready) begin
        pending = 0;
      end else if (!pending && in_valid) begin
        pending = 1;
        k = 0;
        ref_op(ctrl, src1, src2, e_res, e_hi, e_zero, e_dz, e_ovf, e_lat);
      end
    end
  end

  // Presents an op and returns one time step after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1;
    ctrl = c;
    src1 = a;
    src2 = b;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    src1 = $urandom;
    src2 = $urandom;
    ctrl = 4'($urandom);
  endtask

  // Waits for the result, stalls for 'stall' cycles, then completes the handshake.
  task automatic collect(input int stall, output logic [W-1:0] r, output logic [W-1:0] h,
                         output logic z, output logic d, output int lt);
    lt = 0;
    out_ready = 1'b0;
    while (!out_valid && lt < 100) begin
      @(posedge clk);
      #1;
      lt++;
    end
    if (!out_valid) chk("result_timeout", 0, 1);
    r = result;
    h = hi;
    z = zero;
    d = dz;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r, h;
    logic         z, d;
    int           lt;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    src1 = '0;
    src2 = '0;
    ctrl = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(4'd4, 32'hFFFF_FFFF, 32'd1);
    collect(0, r, h, z, d, lt);
    chk("addu_wrap_res", r, 0);
    chk("addu_wrap_zero", z, 1);
    chk("addu_wrap_hi", h, 0);
    chk("addu_wrap_lat", lt, 0);
`ifdef ALU_SEQ_OVF_EN
    chk("addu_wrap_ovf", ovf, 0);
`endif

    issue(4'd6, 32'hFFFF_FFFE, 32'd1);
    collect(0, r, h, z, d, lt);
    chk("slt_neg", r, 1);
    issue(4'd10, 32'hFFFF_FFFE, 32'd1);
    collect(0, r, h, z, d, lt);
    chk("sltu_big", r, 0);

    issue(4'd8, 32'h8000_0000, 32'd4);
    collect(0, r, h, z, d, lt);
    chk("mulu_lat", lt, 32);
    chk("mulu_hi", h, 2);
    chk("mulu_res", r, 0);
    chk("mulu_zero", z, 1);

    issue(4'd9, 32'd100, 32'd7);
    collect(0, r, h, z, d, lt);
    chk("divu_lat", lt, 32);
    chk("divu_quo", r, 14);
    chk("divu_rem", h, 2);

    issue(4'd9, 32'd5, 32'd0);
    collect(0, r, h, z, d, lt);
    chk("dz_lat", lt, 0);
    chk("dz_res", r, 32'hFFFF_FFFF);
    chk("dz_hi", h, 5);
    chk("dz_flag", d, 1);

    // Backpressure with a competing request held during the stall.
    issue(4'd0, 32'h0000_F0F0, 32'h0000_FF00);
    in_valid = 1'b1;
    ctrl = 4'd4;
    src1 = 32'd10;
    src2 = 32'd20;
    collect(5, r, h, z, d, lt);
    chk("and_res", r, 32'h0000_F000);
    chk("ready_after_hs", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    collect(0, r, h, z, d, lt);
    chk("held_addu_res", r, 30);

    // Reset in the middle of a multiply.
    issue(4'd8, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_result", result, 0);
    chk("midrst_hi", hi, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(4'd4, 32'd2, 32'd3);
    collect(0, r, h, z, d, lt);
    chk("post_rst_addu", r, 5);

    repeat (150) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      issue(4'($urandom_range(0, 15)), pick(), pick());
      collect($urandom_range(0, 3), r, h, z, d, lt);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle CPU ALU.
- Executes the existing logic, arithmetic and compare ops in one registered cycle.
- Adds iterative unsigned multiply (shift-add) and divide (restoring), each taking WIDTH cycles.
- Sits in the EX stage of the multi-cycle/pipelined core; the stall logic watches in_ready_o and out_valid_o.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4 to 64.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  operands and ctrl_i are valid this cycle.
- in_ready_o  output  1  block can accept an op; high only in IDLE.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- ctrl_i  input  4  opcode, see Behaviour.
- out_valid_o  output  1  result_o, hi_o, zero_o, dz_o are valid.
- out_ready_i  input  1  consumer accepts the result.
- result_o  output  WIDTH  main result; low half of product or quotient.
- hi_o  output  WIDTH  high half of product or remainder; 0 for other ops.
- zero_o  output  1  result_o == 0.
- dz_o  output  1  DIVU executed with src2 == 0.

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 NAND, 3 NOR: bitwise.
  - 4 ADDU, 5 SUBU: modulo 2^WIDTH.
  - 6 SLT: signed A<B gives 1, else 0.
  - 7 EQUAL: A==B gives 1, else 0.
  - 8 MULU, 9 DIVU: iterative, see below.
  - 10 SLTU: unsigned A<B gives 1, else 0.
  - 11-15: result 0, single-cycle.
- Operand capture: src1_i, src2_i and ctrl_i are registered on the accept edge (in_valid_i && in_ready_o). Inputs are ignored at all other times.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready_o=1, out_valid_o=0.
  - On accept with a single-cycle op: compute and register the result, go to DONE.
  - On accept with MULU/DIVU: go to BUSY with the counter at 0.
  - On accept with DIVU and src2==0: skip BUSY and go straight to DONE with result_o=all ones, hi_o=src1, dz_o=1.
- BUSY:
  - in_ready_o=0.
  - One iteration per cycle; counter increments each cycle.
  - When counter==WIDTH-1, the last iteration completes and the state goes to DONE.
- DONE:
  - out_valid_o=1; outputs held stable.
  - When out_ready_i=1, return to IDLE.
  - No accept is allowed in DONE: in_ready_o=0.
- Latency, with the accept edge at cycle N:
  - Single-cycle ops and divide-by-zero: out_valid_o high from N+1.
  - MULU/DIVU: out_valid_o high from N+WIDTH+1.
- Throughput: one op per (latency + 1) cycles at best, because the IDLE cycle follows the result handshake.
- MULU: full 2*WIDTH-bit product, split as {hi_o, result_o}.
- DIVU: result_o = A/B, hi_o = A%B, both unsigned.
- hi_o=0 and dz_o=0 for every op except MULU/DIVU.
- zero_o is registered together with result_o; it is meaningful only while out_valid_o=1.
- Reset (rst_i low, at any time including mid-BUSY or in DONE):
  - State goes to IDLE immediately, asynchronously.
  - Counter and all result registers clear.
  - out_valid_o=0, result_o=0, hi_o=0, zero_o=0, dz_o=0, in_ready_o=1.
  - Any in-flight op is discarded; no result is produced for it.
- in_valid_i asserted while not ready: ignored, with no side effects. Upstream must hold it until accepted.

Optional Feature:
- Macro: ALU_SEQ_OVF_EN.
- Defined:
  - Adds output port ovf_o, width 1, registered alongside result_o.
  - ADDU/SUBU: ovf_o = signed two's-complement overflow of the operation.
  - MULU: ovf_o = (hi_o != 0).
  - All other ops: ovf_o = 0.
  - ovf_o resets to 0.
- Undefined: port ovf_o is absent; all other behaviour is unchanged.

Test Plan (WIDTH=32):
- Reset, then ADDU 0xFFFFFFFF+1, out_ready_i=1 → out_valid_o at N+1, result_o=0, zero_o=1, hi_o=0; with ALU_SEQ_OVF_EN, ovf_o=0.
- SLT with A=0xFFFFFFFE (-2), B=1 → result_o=1. SLTU with the same operands → result_o=0.
- MULU 0x80000000×4 → out_valid_o exactly at N+33, hi_o=2, result_o=0, zero_o=1. in_ready_o stays low throughout N+1..N+33.
- DIVU 100/7 → out_valid_o at N+33, result_o=14, hi_o=2. DIVU 5/0 → out_valid_o at N+1, result_o=0xFFFFFFFF, hi_o=5, dz_o=1.
- Backpressure: ANDs 0xF0F0 & 0xFF00 with out_ready_i held low for 5 cycles → out_valid_o stays 1 and result_o stays 0xF000 until out_ready_i rises. A new in_valid_i during the stall is not accepted. in_ready_o returns to 1 the cycle after the handshake.
- Reset mid-op: assert rst_i low at N+10 of a MULU → out_valid_o=0 and in_ready_o=1 immediately. After release, an ADDU 2+3 completes with result_o=5 and no stale MULU result ever appears.
